// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared types and helpers for the sequential shift-and-add multiplier.
//   state_t    : controller state encoding (IDLE, RUN, DONE), 2 bits
//   cnt_width  : iteration counter width for a given operand width
package mul_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/adder_nbit.sv
// adder_nbit: WIDTH-bit adder; the carry-out is dropped so the sum wraps modulo 2^WIDTH.
//   a, b : addends
//   sum  : (a + b) mod 2^WIDTH
module adder_nbit #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/mul_seq_datapath.sv
// mul_seq_datapath: accumulator, multiplicand and multiplier registers around one shared adder.
//   clk, rst_n : clock and asynchronous active-low reset
//   load       : capture a/b and clear the accumulator
//   step       : perform one shift-and-add iteration
//   a, b       : multiplicand and multiplier operands
//   sum        : accumulator value after the current iteration (valid while stepping)
//   rest_zero  : no set bits remain in the multiplier after the current shift
module mul_seq_datapath #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             rest_zero
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] addend;

    assign addend    = mplier[0] ? mcand : '0;
    assign rest_zero = (mplier[WIDTH-1:1] == '0);

    adder_nbit #(.WIDTH(WIDTH)) u_add (
        .a   (acc),
        .b   (addend),
        .sum (sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
        end else if (step) begin
            acc    <= sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/mul_int_seq_ctrl.sv
// mul_int_seq_ctrl: sequential shift-and-add multiplier returning the low WIDTH bits of A*B.
//   clk, rst_n          : clock and asynchronous active-low reset
//   in_valid, in_ready  : operand handshake (accepts A, B only in IDLE)
//   A, B                : multiplicand and multiplier
//   out_valid, out_ready: result handshake (P held stable in DONE until accepted)
//   P                   : registered product, holds its last value in IDLE
//   busy                : high in RUN or DONE
// Optional: define MUL_SEQ_EARLY_TERM_EN to leave RUN as soon as no multiplier bits
// remain, and to skip RUN entirely when B is zero.
module mul_int_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] P,
    output logic             busy
);

`ifdef MUL_SEQ_EARLY_TERM_EN
    localparam bit EARLY_TERM = 1'b1;
`else
    localparam bit EARLY_TERM = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum;
    logic             rest_zero;
    logic             accept;
    logic             run;
    logic             skip;
    logic             last_step;

    assign accept    = in_valid && in_ready;
    assign run       = (state == RUN);
    assign skip      = EARLY_TERM && (B == '0);
    assign last_step = (cnt == LAST) || (EARLY_TERM && rest_zero);

    mul_seq_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .step      (run),
        .a         (A),
        .b         (B),
        .sum       (sum),
        .rest_zero (rest_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = (state == IDLE) ? (accept ? (skip ? DONE : RUN) : IDLE) :
                    (state == RUN)  ? (last_step ? DONE : RUN) :
                    (state == DONE) ? (out_ready ? IDLE : DONE) : IDLE;
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == RUN) || (state == DONE);
    end

    // P captures the final sum on the step that enters DONE, so it is valid
    // together with out_valid; a skipped RUN yields a zero product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            P   <= '0;
        end else begin
            cnt <= accept ? '0 : run ? cnt + 1'b1 : cnt;
            if (run && last_step) P <= sum;
            else if (accept && skip) P <= '0;
        end
    end

endmodule

// File: tb/tb_mul_int_seq_ctrl.sv
// tb_mul_int_seq_ctrl: directed self-checking bench for mul_int_seq_ctrl (WIDTH=4).
module tb_mul_int_seq_ctrl;

    localparam int W = 4;

`ifdef MUL_SEQ_EARLY_TERM_EN
    localparam int LAT_B0 = 1;
    localparam int LAT_B2 = 3;
`else
    localparam int LAT_B0 = 5;
    localparam int LAT_B2 = 5;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [W-1:0] P;

    int compared = 0;
    int mismatched = 0;

    mul_int_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (P),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Counts edges from the accept edge (counted as 1) until out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input int exp_lat, input logic [W-1:0] exp_p);
        int lat;
        A = a;
        B = b;
        in_valid = 1'b1;
        out_ready = 1'b1;
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        A = ~a;
        B = ~b;
        wait_valid(lat);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_p"}, 32'(P), 32'(exp_p));
        tick();
        chk({tag, "_idle"}, 32'({in_ready, out_valid, busy}), 32'b100);
        chk({tag, "_phold"}, 32'(P), 32'(exp_p));
    endtask

    initial begin
        int lat;
        bit seen;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async", 32'({in_ready, out_valid, busy}), 32'b100);
        chk("rst_p", 32'(P), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_hold", 32'({in_ready, out_valid, busy}), 32'b100);

        op("m3x5", 4'd3, 4'd5, 5, 4'd15);
        op("m7x7", 4'd7, 4'd7, 5, 4'd1);
        op("m15x15", 4'd15, 4'd15, 5, 4'd1);

        A = 4'd2;
        B = 4'd6;
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("bp_busy", 32'({in_ready, out_valid, busy}), 32'b001);
        wait_valid(lat);
        chk("bp_lat", 32'(lat), 32'd5);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp_hold%0d", i), 32'({out_valid, in_ready, P}), {26'd0, 1'b1, 1'b0, 4'd12});
            tick();
        end
        out_ready = 1'b1;
        chk("bp_last", 32'({out_valid, P}), {27'd0, 1'b1, 4'd12});
        tick();
        chk("bp_done", 32'({in_ready, out_valid, busy}), 32'b100);

        A = 4'd9;
        B = 4'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("mr_busy", 32'({in_ready, out_valid, busy}), 32'b001);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_async", 32'({in_ready, out_valid, busy}), 32'b100);
        chk("mr_p", 32'(P), 32'd0);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("mr_noval", 32'(seen), 32'd0);

        A = 4'd1;
        B = 4'd1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        A = 4'd4;
        B = 4'd3;
        wait_valid(lat);
        chk("b2b1_lat", 32'(lat), 32'd5);
        chk("b2b1_p", 32'(P), 32'd1);
        chk("b2b1_noacc", 32'(in_ready), 32'd0);
        tick();
        chk("b2b_gap", 32'({in_ready, out_valid}), 32'b10);
        tick();
        in_valid = 1'b0;
        chk("b2b2_busy", 32'(busy), 32'd1);
        wait_valid(lat);
        chk("b2b2_lat", 32'(lat), 32'd5);
        chk("b2b2_p", 32'(P), 32'd12);
        tick();

        op("m5x0", 4'd5, 4'd0, LAT_B0, 4'd0);
        op("m5x2", 4'd5, 4'd2, LAT_B2, 4'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mul_int_seq_ctrl.md
Name: mul_int_seq_ctrl

Overview:
- Sequential shift-and-add integer multiplier controller.
- Sequences a single WIDTH-bit adder over WIDTH iterations instead of using a full array multiplier; trades latency for area in PIM bit-serial flows.
- Returns the lower WIDTH bits of the product, matching the combinational multiplier semantics.
- Valid/ready handshakes on both sides; sits between an operand source and a result consumer.

Parameters:
- WIDTH, 4, operand and result width in bits (≥2).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands A/B valid.
- in_ready  output  1  controller can accept operands.
- A  input  WIDTH  multiplicand.
- B  input  WIDTH  multiplier.
- out_valid  output  1  result P valid.
- out_ready  input  1  consumer accepts P.
- P  output  WIDTH  lower WIDTH bits of A*B.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, acc=0, mcand=0, mplier=0, cnt=0; in_ready=1, out_valid=0, P=0, busy=0.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready: mcand←A, mplier←B, acc←0, cnt←0, go RUN.
  - RUN: per cycle, acc←(acc + (mplier[0] ? mcand : 0)) mod 2^WIDTH; mcand←mcand<<1 (truncated); mplier←mplier>>1; cnt←cnt+1. When cnt==WIDTH-1 (last step), go DONE.
  - DONE: out_valid=1, P=acc, held stable until out_ready. On out_valid&out_ready, go IDLE.
- Latency: out_valid first high exactly WIDTH+1 cycles after the accept edge.
- Throughput: at most one operation per WIDTH+2 cycles; no overlap, so in_ready=0 in RUN and DONE.
- Width rule: all arithmetic is modulo 2^WIDTH; carry-out is discarded.
- P: registered copy of acc; holds its last value in IDLE.
- in_valid in RUN/DONE: ignored; the source must hold it (standard handshake).
- out_ready while not DONE: no effect.
- Reset mid-RUN or mid-DONE: immediate return to reset values; the operation is lost and no out_valid is produced.
- Operands sampled only at accept; later A/B changes do not affect the result.

Optional Feature:
- Macro: MUL_SEQ_EARLY_TERM_EN.
- Defined: in RUN, if the post-shift mplier is zero, go DONE after the current step. If B==0 at accept, skip RUN (IDLE→DONE with acc=0; out_valid one cycle after accept). Latency becomes (index of highest set bit of B)+2 cycles.
- Undefined: fixed WIDTH-cycle RUN regardless of operand values.

Decomposition:
- Package mul_seq_pkg: state enum {IDLE, RUN, DONE} (2-bit encoding), CNT_W derivation function.
- One sub-module: mul_seq_datapath, holding acc/mcand/mplier registers and one adder_nbit instance, driven by load/step enables from the FSM.
- The FSM, counter and handshake logic stay in the top module.

Test Plan:
- A=3, B=5, out_ready=1 → P=15, out_valid exactly 5 cycles after accept (WIDTH=4, no early term).
- A=7, B=7 → P=1 (49 mod 16). A=15, B=15 → P=1 (225 mod 16); carry discarded.
- Backpressure: A=2, B=6, out_ready=0 for 10 cycles → out_valid and P=12 stable throughout, in_ready=0; P accepted on the first out_ready=1 cycle, then in_ready=1.
- Reset mid-RUN: accept A=9, B=3; assert rst_n=0 asynchronously at cycle 2 of RUN → all outputs at reset values immediately; no out_valid after release.
- Back-to-back: in_valid held high with A=1, B=1 then A=4, B=3 → second accept only after the first P=1 handshake; second result P=12.
- MUL_SEQ_EARLY_TERM_EN defined: A=5, B=0 → P=0 one cycle after accept. A=5, B=2 → P=10 three cycles after accept. Undefined: both take 5 cycles.
